// File: rtl/axi_lite_up_bridge.sv
// AXI4-lite slave that converts each transaction into a single-cycle up_* request
// and waits for the matching acknowledge, answering SLVERR if the ack never arrives.
module axi_lite_up_bridge #(
  parameter int ADDRESS_WIDTH = 16,
  parameter int BUS_WIDTH     = 4,
  parameter int TIMEOUT       = 255
) (
  input  logic                       aclk,
  input  logic                       arst,
  input  logic                       s_axi_awvalid,
  input  logic [ADDRESS_WIDTH-1:0]   s_axi_awaddr,
  input  logic [2:0]                 s_axi_awprot,
  output logic                       s_axi_awready,
  input  logic                       s_axi_wvalid,
  input  logic [BUS_WIDTH*8-1:0]     s_axi_wdata,
  input  logic [BUS_WIDTH-1:0]       s_axi_wstrb,
  output logic                       s_axi_wready,
  output logic                       s_axi_bvalid,
  output logic [1:0]                 s_axi_bresp,
  input  logic                       s_axi_bready,
  input  logic                       s_axi_arvalid,
  input  logic [ADDRESS_WIDTH-1:0]   s_axi_araddr,
  input  logic [2:0]                 s_axi_arprot,
  output logic                       s_axi_arready,
  output logic                       s_axi_rvalid,
  output logic [BUS_WIDTH*8-1:0]     s_axi_rdata,
  output logic [1:0]                 s_axi_rresp,
  input  logic                       s_axi_rready,
  output logic                       up_wreq,
  output logic [ADDRESS_WIDTH-1:0]   up_waddr,
  output logic [BUS_WIDTH*8-1:0]     up_wdata,
  output logic [BUS_WIDTH-1:0]       up_wstrb,
  input  logic                       up_wack,
  output logic                       up_rreq,
  output logic [ADDRESS_WIDTH-1:0]   up_raddr,
  input  logic [BUS_WIDTH*8-1:0]     up_rdata,
  input  logic                       up_rack
);

  localparam int DW  = BUS_WIDTH * 8;
  localparam int LOG = $clog2(BUS_WIDTH);
  localparam int CW  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_REQ, W_WAIT, W_RESP} wstate_t;
  typedef enum logic [1:0] {R_IDLE, R_REQ, R_WAIT, R_DATA} rstate_t;

  // The counter holds the number of cycles since the request pulse and sticks at TIMEOUT.
  function automatic logic [CW-1:0] cnt_inc(input logic [CW-1:0] c);
    if (TIMEOUT == 0 || c == TMAX) return c;
    return c + CW'(1);
  endfunction

  wstate_t r_wstate, w_wstate_n;
  rstate_t r_rstate, w_rstate_n;

  logic            r_aw_got, r_w_got, w_aw_got_n, w_w_got_n;
  logic [CW-1:0]   r_wcnt, w_wcnt_n, r_rcnt, w_rcnt_n;
  logic            r_awready, r_wready, r_bvalid, r_arready, r_rvalid;
  logic [1:0]      r_bresp, w_bresp_n, r_rresp, w_rresp_n;
  logic            r_wreq, r_rreq;
  logic [ADDRESS_WIDTH-1:0] r_waddr, r_raddr;
  logic [DW-1:0]   r_wdata, r_rdata, w_rdata_n;
  logic [BUS_WIDTH-1:0] r_wstrb;

  logic w_aw_hs, w_w_hs, w_ar_hs, w_wtimeout, w_rtimeout;
  logic w_unused_prot;

  assign w_aw_hs    = s_axi_awvalid & r_awready;
  assign w_w_hs     = s_axi_wvalid & r_wready;
  assign w_ar_hs    = s_axi_arvalid & r_arready;
  assign w_wtimeout = (TIMEOUT != 0) && (cnt_inc(r_wcnt) == TMAX);
  assign w_rtimeout = (TIMEOUT != 0) && (cnt_inc(r_rcnt) == TMAX);
  assign w_unused_prot = ^{s_axi_awprot, s_axi_arprot};

  always_comb begin
    w_wstate_n = r_wstate;
    w_aw_got_n = r_aw_got;
    w_w_got_n  = r_w_got;
    w_wcnt_n   = r_wcnt;
    w_bresp_n  = r_bresp;
    case (r_wstate)
      W_IDLE: begin
        w_aw_got_n = r_aw_got | w_aw_hs;
        w_w_got_n  = r_w_got | w_w_hs;
        w_wcnt_n   = '0;
        if (w_aw_got_n && w_w_got_n) w_wstate_n = W_REQ;
      end
      W_REQ: begin
        w_wcnt_n   = cnt_inc(r_wcnt);
        w_wstate_n = W_WAIT;
      end
      W_WAIT: begin
        w_wcnt_n = cnt_inc(r_wcnt);
        if (up_wack) begin
          w_bresp_n  = RESP_OKAY;
          w_wstate_n = W_RESP;
        end else if (w_wtimeout) begin
          w_bresp_n  = RESP_SLVERR;
          w_wstate_n = W_RESP;
        end
      end
      W_RESP: begin
        if (s_axi_bready) begin
          w_aw_got_n = 1'b0;
          w_w_got_n  = 1'b0;
          w_wstate_n = W_IDLE;
        end
      end
      default: w_wstate_n = W_IDLE;
    endcase
  end

  always_ff @(posedge aclk or posedge arst) begin
    if (arst) begin
      r_wstate  <= W_IDLE;
      r_aw_got  <= 1'b0;
      r_w_got   <= 1'b0;
      r_wcnt    <= '0;
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bresp   <= '0;
      r_wreq    <= 1'b0;
      r_waddr   <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
    end else begin
      r_wstate  <= w_wstate_n;
      r_aw_got  <= w_aw_got_n;
      r_w_got   <= w_w_got_n;
      r_wcnt    <= w_wcnt_n;
      r_awready <= (w_wstate_n == W_IDLE) && !w_aw_got_n;
      r_wready  <= (w_wstate_n == W_IDLE) && !w_w_got_n;
      r_bvalid  <= (w_wstate_n == W_RESP);
      r_bresp   <= w_bresp_n;
      r_wreq    <= (w_wstate_n == W_REQ);
      if (w_aw_hs) r_waddr <= s_axi_awaddr >> LOG;
      if (w_w_hs) begin
        r_wdata <= s_axi_wdata;
        r_wstrb <= s_axi_wstrb;
      end
    end
  end

  always_comb begin
    w_rstate_n = r_rstate;
    w_rcnt_n   = r_rcnt;
    w_rresp_n  = r_rresp;
    w_rdata_n  = r_rdata;
    case (r_rstate)
      R_IDLE: begin
        w_rcnt_n = '0;
        if (w_ar_hs) w_rstate_n = R_REQ;
      end
      R_REQ: begin
        w_rcnt_n   = cnt_inc(r_rcnt);
        w_rstate_n = R_WAIT;
      end
      R_WAIT: begin
        w_rcnt_n = cnt_inc(r_rcnt);
        if (up_rack) begin
          w_rdata_n  = up_rdata;
          w_rresp_n  = RESP_OKAY;
          w_rstate_n = R_DATA;
        end else if (w_rtimeout) begin
          w_rdata_n  = '0;
          w_rresp_n  = RESP_SLVERR;
          w_rstate_n = R_DATA;
        end
      end
      R_DATA: begin
        if (s_axi_rready) w_rstate_n = R_IDLE;
      end
      default: w_rstate_n = R_IDLE;
    endcase
  end

  always_ff @(posedge aclk or posedge arst) begin
    if (arst) begin
      r_rstate  <= R_IDLE;
      r_rcnt    <= '0;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rresp   <= '0;
      r_rdata   <= '0;
      r_rreq    <= 1'b0;
      r_raddr   <= '0;
    end else begin
      r_rstate  <= w_rstate_n;
      r_rcnt    <= w_rcnt_n;
      r_arready <= (w_rstate_n == R_IDLE);
      r_rvalid  <= (w_rstate_n == R_DATA);
      r_rresp   <= w_rresp_n;
      r_rdata   <= w_rdata_n;
      r_rreq    <= (w_rstate_n == R_REQ);
      if (w_ar_hs) r_raddr <= s_axi_araddr >> LOG;
    end
  end

  assign s_axi_awready = r_awready;
  assign s_axi_wready  = r_wready;
  assign s_axi_bvalid  = r_bvalid;
  assign s_axi_bresp   = r_bresp;
  assign s_axi_arready = r_arready;
  assign s_axi_rvalid  = r_rvalid;
  assign s_axi_rdata   = r_rdata;
  assign s_axi_rresp   = r_rresp;
  assign up_wreq       = r_wreq;
  assign up_waddr      = r_waddr;
  assign up_wdata      = r_wdata;
  assign up_wstrb      = r_wstrb;
  assign up_rreq       = r_rreq;
  assign up_raddr      = r_raddr;

endmodule

// File: doc/axi_lite_up_bridge.md
Name: axi_lite_up_bridge

Overview:
AXI4-lite slave front end that turns AXI-lite transactions into single-cycle up_* request/acknowledge strobes. It feeds a block RAM or register-file back end through separate write and read request ports.
The block sits directly upstream of axi_lite_block_ram-style consumers. It replaces an opaque bridge with one that forwards write strobes and enforces an acknowledge timeout.
Read and write paths are independent state machines sharing one clock.

Parameters:
ADDRESS_WIDTH, 16, AXI byte-address width (s_axi_awaddr/araddr).
BUS_WIDTH, 4, data bus width in bytes; data width is BUS_WIDTH*8. Must be a power of two, at least 1.
TIMEOUT, 255, cycles to wait for up_wack/up_rack before SLVERR; 0 disables the timeout (wait forever).

Ports:
aclk  in  1  clock; all logic on rising edge
arst  in  1  asynchronous active-high reset
s_axi_awvalid  in  1  write address valid
s_axi_awaddr  in  ADDRESS_WIDTH  write byte address
s_axi_awprot  in  3  ignored
s_axi_awready  out  1  write address ready
s_axi_wvalid  in  1  write data valid
s_axi_wdata  in  BUS_WIDTH*8  write data
s_axi_wstrb  in  BUS_WIDTH  byte strobes
s_axi_wready  out  1  write data ready
s_axi_bvalid  out  1  write response valid
s_axi_bresp  out  2  00 OKAY, 10 SLVERR
s_axi_bready  in  1  write response ready
s_axi_arvalid  in  1  read address valid
s_axi_araddr  in  ADDRESS_WIDTH  read byte address
s_axi_arprot  in  3  ignored
s_axi_arready  out  1  read address ready
s_axi_rvalid  out  1  read data valid
s_axi_rdata  out  BUS_WIDTH*8  read data
s_axi_rresp  out  2  00 OKAY, 10 SLVERR
s_axi_rready  in  1  read data ready
up_wreq  out  1  one-cycle write request
up_waddr  out  ADDRESS_WIDTH  word address = awaddr >> log2(BUS_WIDTH), zero-extended
up_wdata  out  BUS_WIDTH*8  write data
up_wstrb  out  BUS_WIDTH  byte enables
up_wack  in  1  write acknowledge
up_rreq  out  1  one-cycle read request
up_raddr  out  ADDRESS_WIDTH  word address = araddr >> log2(BUS_WIDTH)
up_rdata  in  BUS_WIDTH*8  read data, valid in the up_rack cycle
up_rack  in  1  read acknowledge

Behaviour:
- Reset (arst=1, asynchronous):
  - Every output goes to 0 (ready, valid, resp, data, req, addr, strb).
  - Both FSMs return to IDLE; timeout counters clear.
  - An in-flight transaction is dropped with no response.
- All outputs are registered.
- Write FSM: W_IDLE -> W_REQ -> W_WAIT -> W_RESP.
  - W_IDLE:
    - awready=1 until an address has been latched; wready=1 until data has been latched.
    - AW and W handshakes are accepted in any order, including the same cycle.
    - Once both are latched, go to W_REQ.
  - W_REQ: assert up_wreq for exactly 1 cycle with the latched addr/data/strb. Counter=0. Go to W_WAIT.
  - W_WAIT:
    - up_wack=1 -> bresp=00, enter W_RESP.
    - Counter reaches TIMEOUT (nonzero) with no ack -> bresp=10, enter W_RESP.
    - up_wack is sampled only in W_WAIT; an ack arriving in the same cycle as timeout expiry wins (OKAY).
  - W_RESP:
    - bvalid=1 and held stable until bready.
    - On the bvalid&bready cycle, clear bvalid and return to W_IDLE.
    - Ready signals re-assert the next cycle.
- Read FSM: R_IDLE -> R_REQ -> R_WAIT -> R_DATA.
  - R_IDLE: arready=1; the arvalid&arready handshake latches the address.
  - R_REQ: up_rreq pulses for 1 cycle.
  - R_WAIT: up_rack captures up_rdata into rdata with rresp=00. On timeout, rdata=0 and rresp=10.
  - R_DATA: rvalid held with rdata/rresp stable until rready, then return to R_IDLE.
- Latency with a zero-wait acknowledger (ack the cycle after req):
  - Write: handshake cycle N -> up_wreq N+1 -> up_wack N+2 -> bvalid N+3.
  - Read: same schedule, with rvalid at N+3.
- Read and write FSMs run concurrently. There is no arbitration, and simultaneous up_wreq/up_rreq is legal.
- One outstanding transaction per channel. A new AW/W/AR is not accepted until the previous response completes.
- Stray acks (outside WAIT) are ignored. Late acks after a timeout are ignored.
- Address low bits below log2(BUS_WIDTH) are discarded; no unaligned error is raised.
- The timeout counter saturates at TIMEOUT and never wraps. Its width is clog2(TIMEOUT+1).

Test Plan:
- Write awaddr=0x0010, wdata=0xDEADBEEF, wstrb=0xF, AW and W in the same cycle, ack 1 cycle after req -> up_waddr=0x0004, up_wstrb=0xF, bvalid 3 cycles after the handshake, bresp=00.
- W precedes AW by 5 cycles, wstrb=0x3 -> wready drops after W handshake, awready stays 1; a single up_wreq pulse follows AW with up_wstrb=0x3.
- Read araddr=0x0008, responder returns 0x12345678 with rack; hold rready=0 for 4 cycles -> up_raddr=0x0002, rvalid and rdata=0x12345678 stable for all 4 cycles, cleared on the cycle after rready=1.
- TIMEOUT=8 with no ack -> bresp=10 exactly 8 cycles after up_wreq. Same for a read: rresp=10, rdata=0. A later stray ack must produce no extra response.
- Simultaneous write and read to different addresses -> up_wreq and up_rreq assert in the same cycle, and both responses complete correctly.
- Assert arst while in W_WAIT -> all outputs 0 immediately (asynchronously), no bvalid after release, and the next write completes normally.
